// File: rtl/multi_evt_counter_pkg.sv
// Shared constants, types and helpers for the multi-channel event counter.
// The optional sticky overflow output is enabled by defining MULTI_EVT_COUNTER_OVF_EN.
package multi_evt_counter_pkg;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_CNT_W       = 3;
    localparam int DEF_ALMOST_LEAD = 1;

    typedef logic [DEF_CNT_W-1:0] count_t;

    // True when an incremented count lands exactly ALMOST_LEAD below the
    // terminal value; never true when the terminal value is below the lead.
    function automatic logic almost_hit(input int nextCnt, input int limitVal, input int lead);
        return (limitVal >= lead) && (nextCnt == (limitVal - lead));
    endfunction

endpackage

// File: rtl/evt_counter_ch.sv
// One counter channel: count with wrap/saturate, almost and wrap pulses,
// and the combinational wrap condition used to carry into the next channel.
// Sticky overflow flag present only when MULTI_EVT_COUNTER_OVF_EN is defined.
module evt_counter_ch
    import multi_evt_counter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int ALMOST_LEAD = DEF_ALMOST_LEAD
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             evt_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] limit_i,
    input  logic             sat_i,
    output logic [CNT_W-1:0] count_o,
    output logic             almost_o,
    output logic             wrap_o,
`ifdef MULTI_EVT_COUNTER_OVF_EN
    output logic             ovf_o,
`endif
    output logic             wrapCond_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             almost_q, almost_d;
    logic             wrap_q, wrap_d;
`ifdef MULTI_EVT_COUNTER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Carry into the next channel: an accepted event that rolls the count over.
    assign wrapCond_o = evt_i & ~clr_i & ~sat_i & (count_q >= limit_i);

    // Next-state: clear beats events; events increment, wrap, or clamp at the limit.
    always_comb begin
        count_d  = count_q;
        almost_d = 1'b0;
        wrap_d   = 1'b0;
`ifdef MULTI_EVT_COUNTER_OVF_EN
        ovf_d    = ovf_q;
`endif
        if (clr_i) begin
            count_d = '0;
`ifdef MULTI_EVT_COUNTER_OVF_EN
            ovf_d   = 1'b0;
`endif
        end else if (evt_i) begin
            if (count_q < limit_i) begin
                count_d  = count_q + CNT_W'(1);
                almost_d = almost_hit(int'(count_q) + 1, int'(limit_i), ALMOST_LEAD);
            end else if (sat_i) begin
                // Held at the limit already: count and pulses stay quiet.
                // Above the limit (limit was lowered): clamp down to it.
                count_d = limit_i;
`ifdef MULTI_EVT_COUNTER_OVF_EN
                if (count_q == limit_i) begin
                    ovf_d = 1'b1;
                end
`endif
            end else begin
                count_d = '0;
                wrap_d  = 1'b1;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= '0;
            almost_q <= 1'b0;
            wrap_q   <= 1'b0;
`ifdef MULTI_EVT_COUNTER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            count_q  <= count_d;
            almost_q <= almost_d;
            wrap_q   <= wrap_d;
`ifdef MULTI_EVT_COUNTER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign count_o  = count_q;
    assign almost_o = almost_q;
    assign wrap_o   = wrap_q;
`ifdef MULTI_EVT_COUNTER_OVF_EN
    assign ovf_o    = ovf_q;
`endif

endmodule

// File: rtl/multi_evt_counter.sv
// Multi-channel event counter with shared limit, wrap/saturate mode and
// optional cascading (channel k counts on the wrap of channel k-1).
// Define MULTI_EVT_COUNTER_OVF_EN to add the sticky ovf_out output.
module multi_evt_counter
    import multi_evt_counter_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int ALMOST_LEAD = DEF_ALMOST_LEAD
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [NUM_CH-1:0]            evt_in,
    input  logic [NUM_CH-1:0]            clr_in,
    input  logic [CNT_W-1:0]             limit_in,
    input  logic                         sat_in,
    input  logic                         cascade_in,
    output logic [NUM_CH-1:0][CNT_W-1:0] count_out,
    output logic [NUM_CH-1:0]            almost_out,
    output logic [NUM_CH-1:0]            wrap_out
`ifdef MULTI_EVT_COUNTER_OVF_EN
    ,
    output logic [NUM_CH-1:0]            ovf_out
`endif
);

    for (genvar k = 0; k < NUM_CH; k++) begin : gCh
        logic effEvt;
        logic wrapCond;

        // Channel 0 always counts its own event; later channels take the
        // previous channel's same-cycle wrap when cascading is on.
        if (k == 0) begin : gFirst
            assign effEvt = evt_in[k];
        end else begin : gRest
            assign effEvt = cascade_in ? gCh[k-1].wrapCond : evt_in[k];
        end

        evt_counter_ch #(
            .CNT_W       (CNT_W),
            .ALMOST_LEAD (ALMOST_LEAD)
        ) uCh (
            .clk_i      (clk_in),
            .rst_i      (rst_in),
            .evt_i      (effEvt),
            .clr_i      (clr_in[k]),
            .limit_i    (limit_in),
            .sat_i      (sat_in),
            .count_o    (count_out[k]),
            .almost_o   (almost_out[k]),
            .wrap_o     (wrap_out[k]),
`ifdef MULTI_EVT_COUNTER_OVF_EN
            .ovf_o      (ovf_out[k]),
`endif
            .wrapCond_o (wrapCond)
        );
    end

endmodule

// File: doc/multi_evt_counter.md
MULTI_EVT_COUNTER -- requirements
Module: multi_evt_counter

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of independent counter channels (1..16).
REQ-002 The block SHALL have parameter CNT_W, default 3, meaning the width of each channel count.
REQ-003 The block SHALL have parameter ALMOST_LEAD, default 1, meaning the distance below the terminal value at which the almost pulse fires.
REQ-004 The block SHALL have port clk_in, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port evt_in, input, NUM_CH bits: per-channel count-enable event.
REQ-007 The block SHALL have port clr_in, input, NUM_CH bits: per-channel synchronous clear.
REQ-008 The block SHALL have port limit_in, input, CNT_W bits: terminal value shared by all channels, so the count range is 0..limit_in; it is sampled every cycle.
REQ-009 The block SHALL have port sat_in, input, 1 bit: 1 means saturate at limit_in, 0 means wrap to 0.
REQ-010 The block SHALL have port cascade_in, input, 1 bit: 1 means channel k>0 counts on the same-cycle wrap of channel k-1.
REQ-011 The block SHALL have port count_out, output, NUM_CH x CNT_W bits: registered per-channel count.
REQ-012 The block SHALL have port almost_out, output, NUM_CH bits: registered one-cycle almost-terminal pulse.
REQ-013 The block SHALL have port wrap_out, output, NUM_CH bits: registered one-cycle wrap pulse.

Function
REQ-014 The effective event SHALL be evt_in[k] when cascade_in=0 or k=0; otherwise it SHALL be the combinational wrap condition of channel k-1 in the same cycle, and evt_in[k] SHALL be ignored.
REQ-015 The wrap condition of a channel SHALL be: effective event AND count>=limit_in AND sat_in=0, with clr_in low for that channel.
REQ-016 On an effective event with count<limit_in, the count SHALL increment by 1 on the next edge.
REQ-017 On an effective event with count>=limit_in, the count SHALL go to 0 when sat_in=0 and to limit_in when sat_in=1.
REQ-018 wrap_out[k] SHALL be high for exactly the cycle in which count_out[k] first shows 0 after a wrap.
REQ-019 almost_out[k] SHALL be high for exactly the cycle in which count_out[k] first shows limit_in-ALMOST_LEAD as the result of an increment.
REQ-020 almost_out[k] SHALL never fire when limit_in<ALMOST_LEAD.
REQ-021 An event on a channel already held at limit_in with sat_in=1 SHALL leave the count unchanged and produce no pulses.
REQ-022 clr_in[k] SHALL take priority over any event: the count goes to 0 next cycle, no pulses are produced, and no cascade carry is propagated to channel k+1.
REQ-023 With no event and no clear, the count SHALL hold and both pulse outputs SHALL be 0.
REQ-024 If limit_in is lowered below the current count, the next event SHALL be handled per REQ-017 (wrap or clamp); no other action is taken.

Reset
REQ-025 While rst_in=1, on the next edge all count_out, almost_out, wrap_out (and ovf_out when present) SHALL be 0, regardless of evt_in and clr_in.
REQ-026 Reset mid-count SHALL discard all state, and counting SHALL resume from 0 on the first cycle after rst_in falls.

Configuration
REQ-027 With macro MULTI_EVT_COUNTER_OVF_EN defined, the block SHALL add output ovf_out (NUM_CH bits, sticky), set by an event that meets REQ-021 and cleared by clr_in[k] or reset.
REQ-028 Without MULTI_EVT_COUNTER_OVF_EN, the ovf_out port and its logic SHALL be absent, and REQ-021 events SHALL be silently dropped.

Structure
REQ-029 Package multi_evt_counter_pkg SHALL hold the default parameter constants and the count typedef.
REQ-030 Sub-module evt_counter_ch SHALL implement one channel (count, almost, wrap and optional ovf, exposing its wrap condition) and be instantiated NUM_CH times via generate, with the cascade muxing in the top level.

Verification (NUM_CH=4, CNT_W=3, ALMOST_LEAD=1, limit_in=5)
REQ-031 Wrap scenario: sat_in=0, 6 consecutive evt_in[0] -> count_out[0] 1,2,3,4,5,0; almost_out[0] high with count 4; wrap_out[0] high with count 0.
REQ-032 Saturate scenario: sat_in=1, 8 events on ch1 -> count_out[1] sticks at 5, no wrap_out; with OVF_EN, ovf_out[1] rises after the 6th event.
REQ-033 Cascade scenario: cascade_in=1, limit_in=1, evt_in[0] high 8 cycles -> channels form a binary counter, ending with ch3=1 and ch0..2=0.
REQ-034 Clear-versus-event scenario: ch2 at 3, clr_in[2] and evt_in[2] in the same cycle -> count 0, no pulses.
REQ-035 Limit-lowering scenario: ch0 at 4, limit_in changed to 2, one event with sat_in=0 -> count 0 and wrap_out[0] pulse.
REQ-036 Reset scenario: rst_in pulsed while all channels are counting -> all outputs 0 next cycle, and counting restarts from 0.
